// File: rtl/pipe_regs_fde.sv
// pipe_regs_fde
// F, D and E pipeline registers of the Y86-64 pipelined processor.
// Each register advances, holds or squashes on every rising edge under
// the stall/bubble controls from hazard logic. Two saturating counters
// record decode stalls and inserted execute bubbles for hazard profiling.
// Every output is driven straight from a flop.

module pipe_regs_fde #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  // Hazard control
  input  logic          Fs,
  input  logic          Fb,
  input  logic          Ds,
  input  logic          Db,
  input  logic          Es,
  input  logic          Eb,

  // Fetch stage outputs
  input  logic [W-1:0]  f_predPC,
  input  logic [3:0]    f_stat,
  input  logic [3:0]    f_icode,
  input  logic [3:0]    f_ifun,
  input  logic [3:0]    f_rA,
  input  logic [3:0]    f_rB,
  input  logic [W-1:0]  f_valC,
  input  logic [W-1:0]  f_valP,

  // Decode stage outputs
  input  logic [3:0]    d_stat,
  input  logic [3:0]    d_icode,
  input  logic [3:0]    d_ifun,
  input  logic [3:0]    d_dstE,
  input  logic [3:0]    d_dstM,
  input  logic [3:0]    d_srcA,
  input  logic [3:0]    d_srcB,
  input  logic [W-1:0]  d_valC,
  input  logic [W-1:0]  d_valA,
  input  logic [W-1:0]  d_valB,

  // F register
  output logic [W-1:0]  F_predPC,

  // D register
  output logic [3:0]    D_stat,
  output logic [3:0]    D_icode,
  output logic [3:0]    D_ifun,
  output logic [3:0]    D_rA,
  output logic [3:0]    D_rB,
  output logic [W-1:0]  D_valC,
  output logic [W-1:0]  D_valP,

  // E register
  output logic [3:0]    E_stat,
  output logic [3:0]    E_icode,
  output logic [3:0]    E_ifun,
  output logic [3:0]    E_dstE,
  output logic [3:0]    E_dstM,
  output logic [3:0]    E_srcA,
  output logic [3:0]    E_srcB,
  output logic [W-1:0]  E_valC,
  output logic [W-1:0]  E_valA,
  output logic [W-1:0]  E_valB,

  // Hazard event counters
  output logic [CW-1:0] cnt_dstall,
  output logic [CW-1:0] cnt_ebubble
);

  // Y86-64 encodings used to build the NOP (bubble) register image
  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] F_NONE   = 4'h0;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   rA;
    logic [3:0]   rB;
    logic [W-1:0] valC;
    logic [W-1:0] valP;
  } d_reg_t;

  typedef struct packed {
    logic [3:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
    logic [W-1:0] valC;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
  } e_reg_t;

  localparam d_reg_t D_NOP = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  F_NONE,
    rA:    R_NONE,
    rB:    R_NONE,
    valC:  '0,
    valP:  '0
  };

  localparam e_reg_t E_NOP = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    ifun:  F_NONE,
    dstE:  R_NONE,
    dstM:  R_NONE,
    srcA:  R_NONE,
    srcB:  R_NONE,
    valC:  '0,
    valA:  '0,
    valB:  '0
  };

  logic [W-1:0]  r_f_predpc;
  d_reg_t        r_d;
  e_reg_t        r_e;
  logic [CW-1:0] r_cnt_dstall;
  logic [CW-1:0] r_cnt_ebubble;

  d_reg_t        w_d_next;
  e_reg_t        w_e_next;
  logic          w_f_hold;
  logic          w_dstall_evt;
  logic          w_ebubble_evt;

  // F has no bubble form, so a fetch bubble simply freezes the PC.
  assign w_f_hold = Fs | Fb;

  // Count a decode stall on every stall edge; count an execute bubble only
  // when it is really inserted (a simultaneous stall wins and holds E).
  assign w_dstall_evt  = Ds;
  assign w_ebubble_evt = Eb & ~Es;

  // Pack fetch outputs into the D register image
  assign w_d_next = '{
    stat:  f_stat,
    icode: f_icode,
    ifun:  f_ifun,
    rA:    f_rA,
    rB:    f_rB,
    valC:  f_valC,
    valP:  f_valP
  };

  // Pack decode outputs into the E register image
  assign w_e_next = '{
    stat:  d_stat,
    icode: d_icode,
    ifun:  d_ifun,
    dstE:  d_dstE,
    dstM:  d_dstM,
    srcA:  d_srcA,
    srcB:  d_srcB,
    valC:  d_valC,
    valA:  d_valA,
    valB:  d_valB
  };

  // F register: clear on reset, hold on stall or bubble, else take next PC
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // a blocking = here would let later blocks see this edge's new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_f_predpc <= '0;
    end else if (!w_f_hold) begin
      r_f_predpc <= f_predPC;
    end
  end

  // D register: reset to NOP, then stall > bubble > normal load
  // NOTE: stall is tested before bubble, so the illegal Ds&Db case holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d <= D_NOP;
    end else if (Ds) begin
      r_d <= r_d;
    end else if (Db) begin
      r_d <= D_NOP;
    end else begin
      r_d <= w_d_next;
    end
  end

  // E register: reset to NOP, then stall > bubble > normal load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_e <= E_NOP;
    end else if (Es) begin
      r_e <= r_e;
    end else if (Eb) begin
      r_e <= E_NOP;
    end else begin
      r_e <= w_e_next;
    end
  end

  // Decode-stall counter: saturating, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_dstall <= '0;
    end else if (w_dstall_evt && (r_cnt_dstall != CNT_MAX)) begin
      r_cnt_dstall <= r_cnt_dstall + 1'b1;
    end
  end

  // Execute-bubble counter: saturating, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_ebubble <= '0;
    end else if (w_ebubble_evt && (r_cnt_ebubble != CNT_MAX)) begin
      r_cnt_ebubble <= r_cnt_ebubble + 1'b1;
    end
  end

  // Register outputs
  assign F_predPC   = r_f_predpc;

  assign D_stat     = r_d.stat;
  assign D_icode    = r_d.icode;
  assign D_ifun     = r_d.ifun;
  assign D_rA       = r_d.rA;
  assign D_rB       = r_d.rB;
  assign D_valC     = r_d.valC;
  assign D_valP     = r_d.valP;

  assign E_stat     = r_e.stat;
  assign E_icode    = r_e.icode;
  assign E_ifun     = r_e.ifun;
  assign E_dstE     = r_e.dstE;
  assign E_dstM     = r_e.dstM;
  assign E_srcA     = r_e.srcA;
  assign E_srcB     = r_e.srcB;
  assign E_valC     = r_e.valC;
  assign E_valA     = r_e.valA;
  assign E_valB     = r_e.valB;

  assign cnt_dstall  = r_cnt_dstall;
  assign cnt_ebubble = r_cnt_ebubble;

endmodule

// File: tb/tb_pipe_regs_fde.sv
// tb_pipe_regs_fde
// Directed, table-driven bench for pipe_regs_fde with 4-bit counters so
// saturation is reachable. Inputs change on the falling edge, outputs are
// sampled 1 ns after the rising edge.

module tb_pipe_regs_fde;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          Fs, Fb, Ds, Db, Es, Eb;
  logic [W-1:0]  f_predPC;
  logic [3:0]    f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [W-1:0]  f_valC, f_valP;
  logic [3:0]    d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [W-1:0]  d_valC, d_valA, d_valB;
  logic [W-1:0]  F_predPC;
  logic [3:0]    D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0]  D_valC, D_valP;
  logic [3:0]    E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [W-1:0]  E_valC, E_valA, E_valB;
  logic [CW-1:0] cnt_dstall, cnt_ebubble;

  pipe_regs_fde #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Fs         (Fs),
    .Fb         (Fb),
    .Ds         (Ds),
    .Db         (Db),
    .Es         (Es),
    .Eb         (Eb),
    .f_predPC   (f_predPC),
    .f_stat     (f_stat),
    .f_icode    (f_icode),
    .f_ifun     (f_ifun),
    .f_rA       (f_rA),
    .f_rB       (f_rB),
    .f_valC     (f_valC),
    .f_valP     (f_valP),
    .d_stat     (d_stat),
    .d_icode    (d_icode),
    .d_ifun     (d_ifun),
    .d_dstE     (d_dstE),
    .d_dstM     (d_dstM),
    .d_srcA     (d_srcA),
    .d_srcB     (d_srcB),
    .d_valC     (d_valC),
    .d_valA     (d_valA),
    .d_valB     (d_valB),
    .F_predPC   (F_predPC),
    .D_stat     (D_stat),
    .D_icode    (D_icode),
    .D_ifun     (D_ifun),
    .D_rA       (D_rA),
    .D_rB       (D_rB),
    .D_valC     (D_valC),
    .D_valP     (D_valP),
    .E_stat     (E_stat),
    .E_icode    (E_icode),
    .E_ifun     (E_ifun),
    .E_dstE     (E_dstE),
    .E_dstM     (E_dstM),
    .E_srcA     (E_srcA),
    .E_srcB     (E_srcB),
    .E_valC     (E_valC),
    .E_valA     (E_valA),
    .E_valB     (E_valB),
    .cnt_dstall (cnt_dstall),
    .cnt_ebubble(cnt_ebubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: controls, varying f_*/d_* inputs, and expected outputs.
  // Inputs not listed stay at fixed markers: f_rA=5, d_dstM=6, f_stat=d_stat=0.
  typedef struct {
    logic         rst_n, fs, fb, ds, db, es, eb;
    logic [3:0]   fi, frb;
    logic [63:0]  fvc, fpc;
    logic [3:0]   di, dde;
    logic [63:0]  dvc;
    logic [63:0]  x_pc;
    logic [3:0]   x_dstat, x_dicode, x_dra, x_drb;
    logic [63:0]  x_dvalc;
    logic [3:0]   x_estat, x_eicode, x_edste, x_edstm;
    logic [63:0]  x_evalc;
    logic [3:0]   x_cd, x_ce;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic r, input logic fs_i, input logic fb_i, input logic ds_i,
                         input logic db_i, input logic es_i, input logic eb_i);
    rst_n = r; Fs = fs_i; Fb = fb_i; Ds = ds_i; Db = db_i; Es = es_i; Eb = eb_i;
  endtask

  task automatic check_vec(input int n, input vec_t v);
    string p;
    p = $sformatf("v%0d", n);
    check({p, ".F_predPC"},    F_predPC,    v.x_pc);
    check({p, ".D_stat"},      D_stat,      v.x_dstat);
    check({p, ".D_icode"},     D_icode,     v.x_dicode);
    check({p, ".D_rA"},        D_rA,        v.x_dra);
    check({p, ".D_rB"},        D_rB,        v.x_drb);
    check({p, ".D_valC"},      D_valC,      v.x_dvalc);
    check({p, ".E_stat"},      E_stat,      v.x_estat);
    check({p, ".E_icode"},     E_icode,     v.x_eicode);
    check({p, ".E_dstE"},      E_dstE,      v.x_edste);
    check({p, ".E_dstM"},      E_dstM,      v.x_edstm);
    check({p, ".E_valC"},      E_valC,      v.x_evalc);
    check({p, ".cnt_dstall"},  cnt_dstall,  v.x_cd);
    check({p, ".cnt_ebubble"}, cnt_ebubble, v.x_ce);
  endtask

  initial begin
    // rst fs fb ds db es eb | fi frb fvc fpc | di dde dvc | pc | D stat icode rA rB valC | E stat icode dstE dstM valC | cd ce
    // normal flow: first fetch set, then decode values reach E
    vecs[0]  = '{1,0,0,0,0,0,0, 3, 2, 'h100,'h0A,  0, 0, 'h0,   'h0A, 0, 3,5, 2,'h100, 0, 0, 0, 6,'h0,   0,0};
    vecs[1]  = '{1,0,0,0,0,0,0, 6, 1, 'h200,'h14,  3, 2, 'h100, 'h14, 0, 6,5, 1,'h200, 0, 3, 2, 6,'h100, 0,0};
    // load/use: F and D hold, E bubbles
    vecs[2]  = '{1,1,0,1,0,0,1, 7, 3, 'h300,'h1E,  6, 1, 'h200, 'h14, 0, 6,5, 1,'h200, 1, 1,15,15,'h0,   1,1};
    vecs[3]  = '{1,0,0,0,0,0,0, 7, 3, 'h300,'h1E,  6, 1, 'h200, 'h1E, 0, 7,5, 3,'h300, 0, 6, 1, 6,'h200, 1,1};
    // mispredict: D and E squashed, F loads
    vecs[4]  = '{1,0,0,0,1,0,1, 2, 4, 'h400,'h28,  7, 3, 'h300, 'h28, 1, 1,15,15,'h0,  1, 1,15,15,'h0,   1,2};
    vecs[5]  = '{1,0,0,0,0,0,0, 5, 6, 'h500,'h32,  1,15, 'h0,   'h32, 0, 5,5, 6,'h500, 0, 1,15, 6,'h0,   1,2};
    // ret: Fs=Db for three edges, E keeps loading
    vecs[6]  = '{1,1,0,0,1,0,0, 9, 9, 'h900,'h90,  5, 6, 'h500, 'h32, 1, 1,15,15,'h0,  0, 5, 6, 6,'h500, 1,2};
    vecs[7]  = '{1,1,0,0,1,0,0, 9, 9, 'h900,'h90,  9, 7, 'h700, 'h32, 1, 1,15,15,'h0,  0, 9, 7, 6,'h700, 1,2};
    vecs[8]  = '{1,1,0,0,1,0,0, 9, 9, 'h900,'h90, 10, 8, 'h800, 'h32, 1, 1,15,15,'h0,  0,10, 8, 6,'h800, 1,2};
    vecs[9]  = '{1,0,0,0,0,0,0,11, 0, 'hB00,'hB0,  1,15, 'h0,   'hB0, 0,11,5, 0,'hB00, 0, 1,15, 6,'h0,   1,2};
    // Es and Eb together: E held, no bubble counted
    vecs[10] = '{1,0,0,0,0,1,1,12, 1, 'hC00,'hC0,  4, 4, 'h444, 'hC0, 0,12,5, 1,'hC00, 0, 1,15, 6,'h0,   1,2};
    // Fb alone holds F; Ds and Db together hold D
    vecs[11] = '{1,0,1,1,1,0,0,13, 2, 'hD00,'hD0,  2, 3, 'h230, 'hC0, 0,12,5, 1,'hC00, 0, 2, 3, 6,'h230, 2,2};
    // Es alone holds E
    vecs[12] = '{1,0,0,0,0,1,0,14, 2, 'hE00,'hE0,  3, 4, 'h340, 'hE0, 0,14,5, 2,'hE00, 0, 2, 3, 6,'h230, 2,2};
    // reset mid-operation overrides stall and bubble
    vecs[13] = '{0,1,0,1,0,0,1, 3, 2, 'h100,'h0A,  3, 2, 'h100, 'h0,  1, 1,15,15,'h0,  1, 1,15,15,'h0,   0,0};
    // first edge after reset honours Ds and Eb
    vecs[14] = '{1,0,0,1,0,0,1, 3, 2, 'h100,'h0A,  3, 2, 'h100, 'h0A, 1, 1,15,15,'h0,  1, 1,15,15,'h0,   1,1};

    // Fixed marker inputs
    f_stat = 4'h0; f_ifun = 4'h2; f_rA = 4'h5; f_valP = 64'h55;
    d_stat = 4'h0; d_ifun = 4'h5; d_dstM = 4'h6; d_srcA = 4'h7; d_srcB = 4'h8;
    d_valA = 64'h99; d_valB = 64'h88;

    // Reset for two edges with random data, Fs=Ds=1 and random bubbles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_ctl(1'b0, 1'b1, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      f_predPC = {$urandom, $urandom};
      f_icode  = 4'($urandom); f_rB = 4'($urandom); f_valC = {$urandom, $urandom};
      d_icode  = 4'($urandom); d_dstE = 4'($urandom); d_valC = {$urandom, $urandom};
      step();
    end
    check("rst.F_predPC",    F_predPC,    64'h0);
    check("rst.D_stat",      D_stat,      64'h1);
    check("rst.D_icode",     D_icode,     64'h1);
    check("rst.D_rA",        D_rA,        64'hF);
    check("rst.E_icode",     E_icode,     64'h1);
    check("rst.E_dstM",      E_dstM,      64'hF);
    check("rst.E_valA",      E_valA,      64'h0);
    check("rst.cnt_dstall",  cnt_dstall,  64'h0);
    check("rst.cnt_ebubble", cnt_ebubble, 64'h0);

    // Table-driven vectors
    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      set_ctl(vecs[n].rst_n, vecs[n].fs, vecs[n].fb, vecs[n].ds, vecs[n].db, vecs[n].es, vecs[n].eb);
      f_icode = vecs[n].fi;  f_rB   = vecs[n].frb; f_valC = vecs[n].fvc; f_predPC = vecs[n].fpc;
      d_icode = vecs[n].di;  d_dstE = vecs[n].dde; d_valC = vecs[n].dvc;
      step();
      check_vec(n, vecs[n]);
    end

    // Saturation: both counters start at 1; Ds and Eb held for 20 edges
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      d_icode = 4'($urandom);
      step();
      if (k == 13) begin
        check("sat13.cnt_dstall",  cnt_dstall,  64'd14);
        check("sat13.cnt_ebubble", cnt_ebubble, 64'd14);
      end
      if (k == 14) begin
        check("sat14.cnt_dstall",  cnt_dstall,  64'd15);
        check("sat14.cnt_ebubble", cnt_ebubble, 64'd15);
      end
    end
    check("sat20.cnt_dstall",  cnt_dstall,  64'd15);
    check("sat20.cnt_ebubble", cnt_ebubble, 64'd15);
    check("sat20.D_icode",     D_icode,     64'h1);
    check("sat20.E_icode",     E_icode,     64'h1);
    check("sat20.F_predPC",    F_predPC,    64'h0A);

    // Control glitch between edges must not disturb the registers
    @(negedge clk);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    f_predPC = 64'h1234;
    #2 Fs = 1'b0; Ds = 1'b0; Es = 1'b0;
    #1 Fs = 1'b1; Ds = 1'b1; Es = 1'b1;
    step();
    check("glitch.F_predPC",   F_predPC,   64'h0A);
    check("glitch.D_icode",    D_icode,    64'h1);
    check("glitch.cnt_dstall", cnt_dstall, 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
